// File: rtl/bcd_disp_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bcd_disp_pkg : shared glyph constants and BCD digit width for display paths
// Revision     : 1.0
// ---------------------------------------------------------------------------
package bcd_disp_pkg;

  localparam int BCD_W = 4;

  // Active-low glyphs, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

endpackage
`default_nettype wire

// File: rtl/bcd_to_seg7.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bcd_to_seg7 : combinational BCD digit to active-low seven-segment glyph
// Revision    : 1.0
// ---------------------------------------------------------------------------
module bcd_to_seg7
  import bcd_disp_pkg::*;
(
  input  logic [BCD_W-1:0] i_bcd,
  output logic [6:0]       o_seg
);

  always_comb begin
    o_seg = SEG_DASH;
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_DASH;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/bcd_seg_scan.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bcd_seg_scan : multiplexed common-anode 7-seg driver, frame-synchronous load
// Revision     : 1.0
// ---------------------------------------------------------------------------
module bcd_seg_scan
  import bcd_disp_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 1000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [BCD_W*NUM_DIGITS-1:0] bcd_in,
  input  logic [NUM_DIGITS-1:0]       dp_in,
  input  logic                        load,
  input  logic                        blank_lz,
  output logic [6:0]                  seg,
  output logic                        dp,
  output logic [NUM_DIGITS-1:0]       an,
  output logic                        scan_tick
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int BUS_W = BCD_W * NUM_DIGITS;

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [BUS_W-1:0]      pend_bcd_q, pend_bcd_d;
  logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
  logic                  pend_valid_q, pend_valid_d;
  logic [BUS_W-1:0]      disp_bcd_q, disp_bcd_d;
  logic [NUM_DIGITS-1:0] disp_dp_q, disp_dp_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;

  logic                  cnt_last;
  logic                  idx_last;
  logic [BCD_W-1:0]      cur_digit;
  logic                  cur_dp;
  logic                  cur_upper_zero;
  logic                  zero_acc;
  logic                  blanked;
  logic [6:0]            glyph;

  assign cnt_last  = (cnt_q == CNT_W'(REFRESH_DIV - 1));
  assign idx_last  = (idx_q == IDX_W'(NUM_DIGITS - 1));
  assign scan_tick = cnt_last;

  bcd_to_seg7 u_dec (
    .i_bcd (cur_digit),
    .o_seg (glyph)
  );

  // Digit select plus "this digit and all above it are zero" scan from the top
  always_comb begin
    cur_digit      = '0;
    cur_dp         = 1'b0;
    cur_upper_zero = 1'b0;
    zero_acc       = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_acc = zero_acc & (disp_bcd_q[k*BCD_W +: BCD_W] == '0);
      if (idx_q == IDX_W'(k)) begin
        cur_digit      = disp_bcd_q[k*BCD_W +: BCD_W];
        cur_dp         = disp_dp_q[k];
        cur_upper_zero = zero_acc;
      end
    end
    blanked = blank_lz && (idx_q != '0) && cur_upper_zero;
  end

  always_comb begin
    cnt_d        = cnt_q + CNT_W'(1);
    idx_d        = idx_q;
    pend_bcd_d   = pend_bcd_q;
    pend_dp_d    = pend_dp_q;
    pend_valid_d = pend_valid_q;
    disp_bcd_d   = disp_bcd_q;
    disp_dp_d    = disp_dp_q;

    if (cnt_last) begin
      cnt_d = '0;
      idx_d = idx_last ? '0 : idx_q + IDX_W'(1);
    end

    // Transfer consumes the old pending word; a coincident load re-arms it
    if (cnt_last && idx_last && pend_valid_q) begin
      disp_bcd_d   = pend_bcd_q;
      disp_dp_d    = pend_dp_q;
      pend_valid_d = 1'b0;
    end
    if (load) begin
      pend_bcd_d   = bcd_in;
      pend_dp_d    = dp_in;
      pend_valid_d = 1'b1;
    end

    seg_d = blanked ? SEG_OFF : glyph;
    dp_d  = blanked ? 1'b1 : ~cur_dp;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      an_d[k] = !((idx_q == IDX_W'(k)) && !blanked);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      pend_bcd_q   <= '0;
      pend_dp_q    <= '0;
      pend_valid_q <= 1'b0;
      disp_bcd_q   <= '0;
      disp_dp_q    <= '0;
      seg_q        <= SEG_OFF;
      dp_q         <= 1'b1;
      an_q         <= '1;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pend_bcd_q   <= pend_bcd_d;
      pend_dp_q    <= pend_dp_d;
      pend_valid_q <= pend_valid_d;
      disp_bcd_q   <= disp_bcd_d;
      disp_dp_q    <= disp_dp_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
    end
  end

  assign seg = seg_q;
  assign dp  = dp_q;
  assign an  = an_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_seg_scan.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_bcd_seg_scan : directed bench with a frame-arithmetic reference model
// Revision        : 1.0
// ---------------------------------------------------------------------------
module tb_bcd_seg_scan;

  localparam int N = 4;
  localparam int R = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [4*N-1:0] bcd_in;
  logic [N-1:0]  dp_in;
  logic          load;
  logic          blank_lz;
  logic [6:0]    seg;
  logic          dp;
  logic [N-1:0]  an;
  logic          scan_tick;

  bcd_seg_scan #(.NUM_DIGITS(N), .REFRESH_DIV(R)) dut (
    .clk       (clk),
    .rst       (rst),
    .bcd_in    (bcd_in),
    .dp_in     (dp_in),
    .load      (load),
    .blank_lz  (blank_lz),
    .seg       (seg),
    .dp        (dp),
    .an        (an),
    .scan_tick (scan_tick)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int k = 0;

  logic [6:0] glyph [16];

  // Reference state: e counts un-reset edges; frame position follows from e
  int         e = 0;
  logic [15:0] m_disp, m_pend;
  logic [3:0] m_ddp, m_pdp;
  bit         m_pv;
  logic [6:0] x_seg;
  logic       x_dp;
  logic [3:0] x_an;
  logic       x_tick;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at k=%0d: got %h, expected %h", name, k, act, exp);
    end
  endtask

  task automatic model_edge();
    int idx;
    bit blank;
    if (rst) begin
      e = 0; m_disp = '0; m_ddp = '0; m_pend = '0; m_pdp = '0; m_pv = 0;
      x_seg = 7'h7F; x_dp = 1'b1; x_an = 4'hF; x_tick = 1'b0;
    end else begin
      idx   = (e / R) % N;
      blank = blank_lz && (idx != 0) && ((m_disp >> (4 * idx)) == 16'h0);
      x_an  = 4'hF;
      if (!blank) x_an[idx] = 1'b0;
      x_seg = blank ? 7'h7F : glyph[(m_disp >> (4 * idx)) & 16'hF];
      x_dp  = blank ? 1'b1 : !m_ddp[idx];
      if ((e % (R * N)) == (R * N - 1) && m_pv) begin
        m_disp = m_pend; m_ddp = m_pdp; m_pv = 0;
      end
      if (load) begin
        m_pend = bcd_in; m_pdp = dp_in; m_pv = 1;
      end
      e++;
      x_tick = ((e % R) == (R - 1));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    k++;
    chk("seg", {9'd0, seg}, {9'd0, x_seg});
    chk("dp", {15'd0, dp}, {15'd0, x_dp});
    chk("an", {12'd0, an}, {12'd0, x_an});
    chk("scan_tick", {15'd0, scan_tick}, {15'd0, x_tick});
  endtask

  task automatic run_to(input int target);
    while (k < target) step();
  endtask

  task automatic do_load(input logic [15:0] b, input logic [3:0] d);
    bcd_in = b; dp_in = d; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic lit(input string name, input logic [3:0] a, input logic [6:0] s);
    chk({name, "_an"}, {12'd0, an}, {12'd0, a});
    chk({name, "_seg"}, {9'd0, seg}, {9'd0, s});
  endtask

  initial begin
    glyph[0] = 7'h40; glyph[1] = 7'h79; glyph[2] = 7'h24; glyph[3] = 7'h30;
    glyph[4] = 7'h19; glyph[5] = 7'h12; glyph[6] = 7'h02; glyph[7] = 7'h78;
    glyph[8] = 7'h00; glyph[9] = 7'h10;
    for (int i = 10; i < 16; i++) glyph[i] = 7'h3F;

    rst = 1'b1; load = 1'b0; bcd_in = '0; dp_in = '0; blank_lz = 1'b0;
    repeat (3) step();
    lit("reset", 4'hF, 7'h7F);
    chk("reset_dp", {15'd0, dp}, 16'd1);
    chk("reset_tick", {15'd0, scan_tick}, 16'd0);

    rst = 1'b0; k = 0;
    step();
    lit("first", 4'b1110, 7'h40);
    run_to(3);
    chk("tick3", {15'd0, scan_tick}, 16'd1);
    run_to(5);
    lit("scan_d1", 4'b1101, 7'h40);
    run_to(13);
    lit("scan_d3", 4'b0111, 7'h40);

    run_to(6 > k ? 6 : k);
    run_to(18);
    do_load(16'h1234, 4'b0000);
    run_to(32);
    lit("hold_old", 4'b0111, 7'h40);
    run_to(33);
    lit("new_d0", 4'b1110, 7'h19);
    run_to(45);
    lit("new_d3", 4'b0111, 7'h79);

    blank_lz = 1'b1;
    run_to(50);
    do_load(16'h0070, 4'b0000);
    run_to(65);
    lit("lz_d0", 4'b1110, 7'h40);
    run_to(69);
    lit("lz_d1", 4'b1101, 7'h78);
    run_to(73);
    lit("lz_d2", 4'b1111, 7'h7F);
    run_to(77);
    lit("lz_d3", 4'b1111, 7'h7F);

    run_to(82);
    do_load(16'h0000, 4'b0000);
    run_to(101);
    lit("zero_d1", 4'b1111, 7'h7F);

    run_to(114);
    do_load(16'hF0A5, 4'b0010);
    run_to(129);
    lit("inv_d0", 4'b1110, 7'h12);
    run_to(133);
    lit("inv_d1", 4'b1101, 7'h3F);
    chk("inv_dp1", {15'd0, dp}, 16'd0);
    run_to(137);
    lit("inv_d2", 4'b1011, 7'h40);
    run_to(141);
    lit("inv_d3", 4'b0111, 7'h3F);

    run_to(146);
    do_load(16'h1111, 4'b0000);
    do_load(16'h2222, 4'b0000);
    run_to(161);
    lit("last_wins", 4'b1110, 7'h24);

    run_to(166);
    do_load(16'h4444, 4'b0000);
    run_to(175);
    do_load(16'h5555, 4'b0000);   // load lands on the transfer edge
    run_to(177);
    lit("coll_old", 4'b1110, 7'h19);
    run_to(193);
    lit("coll_new", 4'b1110, 7'h12);

    run_to(196);
    do_load(16'h6666, 4'b0000);
    blank_lz = 1'b0;
    run_to(201);
    rst = 1'b1;
    step();
    lit("midrst", 4'hF, 7'h7F);
    rst = 1'b0; k = 0;
    step();
    lit("post_rst_d0", 4'b1110, 7'h40);
    run_to(5);
    lit("post_rst_d1", 4'b1101, 7'h40);
    run_to(17);
    lit("pend_lost", 4'b1110, 7'h40);
    run_to(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
